// File: rtl/mips_alu_exec.sv
// MIPS-style decode-and-execute slice: field decode, ALU-op/ALU-control generation,
// 32-bit ALU, and a single output register stage that feeds the register-file write port.
module mips_alu_exec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [3:0]  alu_ctr,
    output logic [31:0] result,
    output logic        zero,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic        illegal
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] CTR_AND = 4'b0000;
    localparam logic [3:0] CTR_OR  = 4'b0001;
    localparam logic [3:0] CTR_ADD = 4'b0010;
    localparam logic [3:0] CTR_SUB = 4'b0110;
    localparam logic [3:0] CTR_SLT = 4'b0111;
    localparam logic [3:0] CTR_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ALU_OP_MEM = 2'b00,
        ALU_OP_BEQ = 2'b01,
        ALU_OP_R   = 2'b10,
        ALU_OP_ILL = 2'b11
    } alu_op_e;

    logic [5:0]        op;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_sext;
    logic              unused_shamt;

    assign op           = inst[31:26];
    assign rs           = inst[25:21];
    assign rt           = inst[20:16];
    assign rd           = inst[15:11];
    assign funct        = inst[5:0];
    assign imm_sext     = DATA_W'({{16{inst[15]}}, inst[15:0]});
    assign unused_shamt = ^inst[10:6];

    alu_op_e           alu_op_c;
    logic              op_illegal_c;
    logic              fn_illegal_c;
    logic [3:0]        alu_ctr_c;
    logic [DATA_W-1:0] opnd_b_c;
    logic [DATA_W-1:0] alu_res_c;
    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;

    // Main decoder: opcode to 2-bit ALU op.
    always_comb begin
        alu_op_c     = ALU_OP_ILL;
        op_illegal_c = 1'b1;
        case (op)
            OP_RTYPE: begin alu_op_c = ALU_OP_R;   op_illegal_c = 1'b0; end
            OP_LW,
            OP_SW:    begin alu_op_c = ALU_OP_MEM; op_illegal_c = 1'b0; end
            OP_BEQ:   begin alu_op_c = ALU_OP_BEQ; op_illegal_c = 1'b0; end
            default:  ;
        endcase
    end

    // ALU decoder: ALU op and funct to 4-bit ALU control.
    always_comb begin
        alu_ctr_c    = CTR_ADD;
        fn_illegal_c = 1'b0;
        case (alu_op_c)
            ALU_OP_MEM: alu_ctr_c = CTR_ADD;
            ALU_OP_BEQ: alu_ctr_c = CTR_SUB;
            ALU_OP_R: begin
                case (funct)
                    FN_ADD:  alu_ctr_c = CTR_ADD;
                    FN_SUB:  alu_ctr_c = CTR_SUB;
                    FN_AND:  alu_ctr_c = CTR_AND;
                    FN_OR:   alu_ctr_c = CTR_OR;
                    FN_NOR:  alu_ctr_c = CTR_NOR;
                    FN_SLT:  alu_ctr_c = CTR_SLT;
                    default: fn_illegal_c = 1'b1;
                endcase
            end
            default: fn_illegal_c = 1'b1;
        endcase
    end

    assign alu_ctr = alu_ctr_c;

    // Operand select and ALU; add/sub wrap, slt is signed.
    always_comb begin
        opnd_b_c = (alu_op_c == ALU_OP_MEM) ? imm_sext : b;
        case (alu_ctr_c)
            CTR_AND: alu_res_c = a & opnd_b_c;
            CTR_OR:  alu_res_c = a | opnd_b_c;
            CTR_SUB: alu_res_c = a - opnd_b_c;
            CTR_SLT: alu_res_c = ($signed(a) < $signed(opnd_b_c)) ? DATA_W'(1) : DATA_W'(0);
            CTR_NOR: alu_res_c = ~(a | opnd_b_c);
            default: alu_res_c = a + opnd_b_c;
        endcase
    end

    // Write-back: legal R-type writes rd, lw writes rt, everything else is silent.
    always_comb begin
        wr_en_c   = ((alu_op_c == ALU_OP_R) && !fn_illegal_c) || (op == OP_LW);
        wr_addr_c = (alu_op_c == ALU_OP_R) ? rd : rt;
    end

    logic [DATA_W-1:0] result_d,  result_q;
    logic              zero_d,    zero_q;
    logic              wr_en_d,   wr_en_q;
    logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
    logic              illegal_d, illegal_q;

    // Idle cycles drop the strobes but keep the last result and address.
    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        illegal_d = 1'b0;
        if (inst_valid) begin
            result_d  = alu_res_c;
            zero_d    = (alu_res_c == '0);
            wr_en_d   = wr_en_c;
            wr_addr_d = wr_addr_c;
            illegal_d = op_illegal_c | fn_illegal_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            illegal_q <= illegal_d;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_alu_exec.sv
// Directed, table-driven bench for mips_alu_exec with hand-written idle and reset sequences.
module tb_mips_alu_exec;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [3:0]  alu_ctr;
    logic [31:0] result;
    logic        zero;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    mips_alu_exec dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .inst_valid (inst_valid),
        .a          (a),
        .b          (b),
        .rs         (rs),
        .rt         (rt),
        .alu_ctr    (alu_ctr),
        .result     (result),
        .zero       (zero),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctr;
        logic        chk_res;
        logic [31:0] res;
        logic        zero;
        logic        wr_en;
        logic        chk_addr;
        logic [4:0]  addr;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".result"},  result,         32'h0);
        check({tag, ".zero"},    32'(zero),      32'h0);
        check({tag, ".wr_en"},   32'(wr_en),     32'h0);
        check({tag, ".wr_addr"}, 32'(wr_addr),   32'h0);
        check({tag, ".illegal"}, 32'(illegal),   32'h0);
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] va, input logic [31:0] vb,
                         input logic v);
        @(negedge clk);
        inst       = i;
        a          = va;
        b          = vb;
        inst_valid = v;
    endtask

    task automatic run_vec(input vec_t v);
        drive(v.inst, v.a, v.b, 1'b1);
        #1;
        check({v.name, ".rs"},      32'(rs),      32'(v.inst[25:21]));
        check({v.name, ".rt"},      32'(rt),      32'(v.inst[20:16]));
        check({v.name, ".alu_ctr"}, 32'(alu_ctr), 32'(v.ctr));
        @(posedge clk);
        #1;
        if (v.chk_res) begin
            check({v.name, ".result"}, result,     v.res);
            check({v.name, ".zero"},   32'(zero),  32'(v.zero));
        end
        check({v.name, ".wr_en"},   32'(wr_en),   32'(v.wr_en));
        if (v.chk_addr)
            check({v.name, ".wr_addr"}, 32'(wr_addr), 32'(v.addr));
        check({v.name, ".illegal"}, 32'(illegal), 32'(v.ill));
    endtask

    initial begin
        //          name       inst          a             b             ctr    cr  res           z     we    ca    ad     il
        vecs[0]  = '{"add",    32'h00221820, 32'd5,        32'd7,        4'b0010, 1, 32'd12,       1'b0, 1'b1, 1'b1, 5'd3, 1'b0};
        vecs[1]  = '{"sub",    32'h00221822, 32'd5,        32'd7,        4'b0110, 1, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0};
        vecs[2]  = '{"slt_n",  32'h0022182A, 32'hFFFFFFFF, 32'd1,        4'b0111, 1, 32'd1,        1'b0, 1'b1, 1'b1, 5'd3, 1'b0};
        vecs[3]  = '{"slt_p",  32'h0022182A, 32'd1,        32'hFFFFFFFF, 4'b0111, 1, 32'd0,        1'b1, 1'b1, 1'b1, 5'd3, 1'b0};
        vecs[4]  = '{"and",    32'h00221824, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 1, 32'hF000F000, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0};
        vecs[5]  = '{"or",     32'h00221825, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 1, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0};
        vecs[6]  = '{"nor",    32'h00221827, 32'hF0F0F0F0, 32'hFF00FF00, 4'b1100, 1, 32'h000F000F, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0};
        vecs[7]  = '{"lw",     32'h8C230010, 32'h100,      32'h55,       4'b0010, 1, 32'h110,      1'b0, 1'b1, 1'b1, 5'd3, 1'b0};
        vecs[8]  = '{"lw_neg", 32'h8C23FFF0, 32'h100,      32'h55,       4'b0010, 1, 32'hF0,       1'b0, 1'b1, 1'b1, 5'd3, 1'b0};
        vecs[9]  = '{"sw",     32'hAC230010, 32'h100,      32'h55,       4'b0010, 1, 32'h110,      1'b0, 1'b0, 1'b0, 5'd0, 1'b0};
        vecs[10] = '{"beq",    32'h10220004, 32'd9,        32'd9,        4'b0110, 1, 32'd0,        1'b1, 1'b0, 1'b0, 5'd0, 1'b0};
        vecs[11] = '{"ill_op", 32'hFC221820, 32'd1,        32'd2,        4'b0010, 0, 32'd0,        1'b0, 1'b0, 1'b0, 5'd0, 1'b1};
        vecs[12] = '{"ill_fn", 32'h00221800, 32'd4,        32'd4,        4'b0010, 0, 32'd0,        1'b0, 1'b0, 1'b0, 5'd0, 1'b1};
        vecs[13] = '{"add_r0", 32'h00220020, 32'd0,        32'd0,        4'b0010, 1, 32'd0,        1'b1, 1'b1, 1'b1, 5'd0, 1'b0};

        rst_n      = 1'b0;
        inst       = 32'h0;
        inst_valid = 1'b0;
        a          = 32'h0;
        b          = 32'h0;
        @(posedge clk);
        #1;
        check_all_zero("reset0");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            run_vec(vecs[i]);

        // Idle cycle after a write: strobe drops, result and address hold.
        run_vec(vecs[0]);
        drive(32'h00A42822, 32'd100, 32'd1, 1'b0);
        @(posedge clk);
        #1;
        check("idle.wr_en",   32'(wr_en),   32'h0);
        check("idle.result",  result,       32'd12);
        check("idle.wr_addr", 32'(wr_addr), 32'd3);
        check("idle.illegal", 32'(illegal), 32'h0);

        // Idle cycle after an illegal instruction clears the flag.
        run_vec(vecs[11]);
        drive(32'hFC221820, 32'd1, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        check("idle_ill.illegal", 32'(illegal), 32'h0);
        check("idle_ill.wr_en",   32'(wr_en),   32'h0);

        // Async reset between edges, with an instruction in flight.
        run_vec(vecs[0]);
        drive(32'h00221822, 32'd5, 32'd7, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        drive(32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish within 20000 time units");
        $fatal(1);
    end

endmodule
